ptcalc_mul_arbiter: RTL and testbench

Shares one 22-bit signed × 7-bit unsigned → 29-bit multiplier among NUM_REQ pt-calculation requesters.
- Round-robin arbitration across requesters.
- Two-stage pipeline: operand register, then product register.
- Each result is returned with the requester ID so consumers can demultiplex.
- Sits between the ptcalc_top sub-functions (sagitta/radius terms) and the shared DSP product resource.

---
 rtl/ptcalc_mul_arb_pkg.sv | 28 ++
 rtl/ptcalc_mul_arb_core.sv | 27 ++
 rtl/ptcalc_mul_arbiter.sv | 121 ++++++++++++
 tb/tb_ptcalc_mul_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptcalc_mul_arb_pkg.sv
// Shared definitions for the pt-calculation multiplier arbiter.
// Holds the default operand/product widths, the requester-ID width helper
// and the packed stage-1 record (valid, id, a, b).
package ptcalc_mul_arb_pkg;

  // Minimum ID width for n requesters (at least 1 bit).
  function automatic int id_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_A_W     = 22;
  localparam int DEF_B_W     = 7;
  localparam int DEF_P_W     = DEF_A_W + DEF_B_W;
  localparam int DEF_ID_W    = id_width(DEF_NUM_REQ);

  // Operand register contents between arbitration and the multiplier.
  typedef struct packed {
    logic                       valid;
    logic [DEF_ID_W-1:0]        id;
    logic signed [DEF_A_W-1:0]  a;
    logic [DEF_B_W-1:0]         b;
  } stage_t;

endpackage

// File: rtl/ptcalc_mul_arb_core.sv
// Combinational signed x unsigned multiplier.
// Ports:
//   i_a  signed A_W-bit operand
//   i_b  unsigned B_W-bit operand (zero-extended before multiplying)
//   o_p  full-precision signed product, P_W = A_W + B_W bits
// Kept in its own module so the DSP mapping sits between two registers.
module ptcalc_mul_arb_core #(
  parameter int A_W = 22,
  parameter int B_W = 7,
  parameter int P_W = A_W + B_W
) (
  input  logic signed [A_W-1:0] i_a,
  input  logic        [B_W-1:0] i_b,
  output logic signed [P_W-1:0] o_p
);

  logic signed [B_W:0]   w_b_ext;
  logic signed [P_W-1:0] w_a_wide;
  logic signed [P_W-1:0] w_b_wide;

  // Zero-extend b by one bit so it multiplies as a non-negative signed value.
  assign w_b_ext  = $signed({1'b0, i_b});
  assign w_a_wide = P_W'(i_a);
  assign w_b_wide = P_W'(w_b_ext);
  assign o_p      = w_a_wide * w_b_wide;

endmodule

// File: rtl/ptcalc_mul_arbiter.sv
// Round-robin arbiter sharing one signed x unsigned multiplier among
// NUM_REQ requesters, with an operand stage and a product stage.
// Ports:
//   ap_clk, ap_rst_n       clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester handshake (one ready at most)
//   req_a, req_b           packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready    product handshake
//   rsp_p, rsp_id          signed product and originating requester
//   busy                   any pipeline stage occupied
module ptcalc_mul_arbiter
  import ptcalc_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_width(NUM_REQ),
  parameter int A_W     = DEF_A_W,
  parameter int B_W     = DEF_B_W,
  parameter int P_W     = A_W + B_W
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [P_W-1:0]         rsp_p,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);

  logic [ID_W-1:0]       r_ptr;
  stage_t                r_s1;
  logic                  r_s2_valid;
  logic signed [P_W-1:0] r_s2_p;
  logic [ID_W-1:0]       r_s2_id;

  logic                  w_adv1;
  logic                  w_adv2;
  logic                  w_any;
  logic [ID_W-1:0]       w_win;
  logic                  w_xfer;
  logic [ID_W-1:0]       w_ptr_next;
  stage_t                w_s1_next;
  logic signed [P_W-1:0] w_p;

  assign w_adv2 = !r_s2_valid | rsp_ready;
  assign w_adv1 = !r_s1.valid | w_adv2;

  // Priority search starting at the pointer. Iterating from the farthest
  // offset down lets the nearest requesting index overwrite the result.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_any = 1'b1;
        w_win = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end

  // Ready is gated by reset so nothing is offered while ap_rst_n is low.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = ap_rst_n & w_any & w_adv1 & (w_win == ID_W'(gi));
  end

  assign w_xfer     = w_any & w_adv1;
  assign w_ptr_next = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

  // Stage 1 refills whenever it can advance; it empties if nobody transfers.
  always_comb begin
    w_s1_next = r_s1;
    if (w_adv1) begin
      w_s1_next.valid = w_xfer;
      if (w_xfer) begin
        w_s1_next.id = w_win;
        w_s1_next.a  = req_a[w_win*A_W +: A_W];
        w_s1_next.b  = req_b[w_win*B_W +: B_W];
      end
    end
  end

  ptcalc_mul_arb_core #(
    .A_W (A_W),
    .B_W (B_W),
    .P_W (P_W)
  ) u_core (
    .i_a (r_s1.a),
    .i_b (r_s1.b),
    .o_p (w_p)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_ptr      <= '0;
      r_s1       <= '0;
      r_s2_valid <= 1'b0;
      r_s2_p     <= '0;
      r_s2_id    <= '0;
    end else begin
      r_s1 <= w_s1_next;
      if (w_xfer) begin
        r_ptr <= w_ptr_next;
      end
      if (w_adv2) begin
        r_s2_valid <= r_s1.valid;
        if (r_s1.valid) begin
          r_s2_p  <= w_p;
          r_s2_id <= r_s1.id;
        end
      end
    end
  end

  assign rsp_valid = r_s2_valid;
  assign rsp_p     = r_s2_p;
  assign rsp_id    = r_s2_id;
  assign busy      = r_s1.valid | r_s2_valid;

endmodule

// File: tb/tb_ptcalc_mul_arbiter.sv
module tb_ptcalc_mul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int A_W     = 22;
  localparam int B_W     = 7;
  localparam int P_W     = 29;

  logic                   ap_clk;
  logic                   ap_rst_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [P_W-1:0]         rsp_p;
  logic [ID_W-1:0]        rsp_id;
  logic                   busy;

  ptcalc_mul_arbiter #(
    .NUM_REQ (NUM_REQ), .ID_W (ID_W), .A_W (A_W), .B_W (B_W), .P_W (P_W)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    longint p;
    int     id;
    int     acc_edge;
  } item_t;

  typedef struct {
    longint p;
    int     id;
  } obs_t;

  int     n_checks = 0;
  int     n_errors = 0;

  // Reference model: ordered list of accepted items plus RR pointer.
  item_t  m_q[$];
  int     m_ptr = 0;
  int     m_edge = 0;
  int     m_wait[NUM_REQ];
  int     m_max_wait = 0;
  int     m_pushes = 0;

  obs_t   dut_log[$];
  int     dut_acc = 0;
  int     dut_pops = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ptr = 0;
    for (int i = 0; i < NUM_REQ; i++) m_wait[i] = 0;
  endtask

  task automatic set_op(input int i, input longint a, input int b);
    req_a[i*A_W +: A_W] = A_W'(a);
    req_b[i*B_W +: B_W] = B_W'(b);
  endtask

  // One clock: called just after a falling edge with inputs already driven.
  task automatic cycle();
    logic [NUM_REQ-1:0] exp_rdy;
    int     win;
    int     idx;
    bit     exp_rv;
    longint pa;
    longint pb;
    #1;
    win = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (m_ptr + k) % NUM_REQ;
      if (win < 0 && req_valid[idx]) win = idx;
    end
    // Two in flight and no drain is the only state that refuses new work.
    exp_rdy = '0;
    if (win >= 0 && !(m_q.size() == 2 && !rsp_ready)) exp_rdy[win] = 1'b1;
    // The oldest item is presented once a full cycle has passed since accept.
    exp_rv = (m_q.size() > 0) && (m_edge > m_q[0].acc_edge + 1);

    check_val("req_ready", longint'(req_ready), longint'(exp_rdy));
    check_val("rsp_valid", longint'(rsp_valid), longint'(exp_rv));
    check_val("busy", longint'(busy), longint'(m_q.size() > 0));
    if (exp_rv) begin
      check_val("rsp_p", longint'($signed(rsp_p)), m_q[0].p);
      check_val("rsp_id", longint'(rsp_id), longint'(m_q[0].id));
    end
    if (rsp_valid && rsp_ready) begin
      dut_log.push_back('{p: longint'($signed(rsp_p)), id: int'(rsp_id)});
      dut_pops++;
    end
    dut_acc += $countones(req_valid & req_ready);

    @(posedge ap_clk);
    if (exp_rv && rsp_ready) void'(m_q.pop_front());
    if (exp_rdy != '0) begin
      pa = longint'($signed(req_a[win*A_W +: A_W]));
      pb = longint'(req_b[win*B_W +: B_W]);
      m_q.push_back('{p: pa * pb, id: win, acc_edge: m_edge});
      m_pushes++;
      m_ptr = (win + 1) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || i == win) m_wait[i] = 0;
        else m_wait[i]++;
        if (m_wait[i] > m_max_wait) m_max_wait = m_wait[i];
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) if (!req_valid[i]) m_wait[i] = 0;
    end
    m_edge++;
    @(negedge ap_clk);
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    ap_rst_n  = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    model_reset();
    #12;
    check_val("rst_rsp_valid", longint'(rsp_valid), 0);
    check_val("rst_busy", longint'(busy), 0);
    check_val("rst_rsp_p", longint'(rsp_p), 0);
    check_val("rst_rsp_id", longint'(rsp_id), 0);
    check_val("rst_req_ready", longint'(req_ready), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // All requesters continuously valid, a=i+1, b=10.
    dut_log.delete();
    for (int i = 0; i < NUM_REQ; i++) set_op(i, i + 1, 10);
    req_valid = '1;
    for (int c = 0; c < 8; c++) cycle();
    idle(3);
    check_val("tput_count", dut_log.size(), 8);
    for (int i = 0; i < 4; i++) begin
      check_val("tput_p", dut_log[i].p, 10 * (i + 1));
      check_val("tput_id", dut_log[i].id, i);
    end
    $display("rr throughput: %0d results", dut_log.size());

    // Backpressure: two accepts fill the pipe, then ready drops.
    dut_log.delete();
    dut_acc = 0;
    set_op(0, 7, 3);
    set_op(1, -9, 5);
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    for (int c = 0; c < 4; c++) cycle();
    check_val("bp_accepts", dut_acc, 2);
    #1;
    check_val("bp_ready_low", longint'(req_ready), 0);
    check_val("bp_hold_id", longint'(rsp_id), 0);
    check_val("bp_hold_p", longint'($signed(rsp_p)), 21);
    @(negedge ap_clk);
    idle(3);
    check_val("bp_count", dut_log.size(), 2);
    if (dut_log.size() == 2) begin
      check_val("bp_first_id", dut_log[0].id, 0);
      check_val("bp_second_id", dut_log[1].id, 1);
      check_val("bp_second_p", dut_log[1].p, -45);
    end
    $display("backpressure: accepts=%0d drained=%0d", dut_acc, dut_log.size());

    // Single requester 2: -5 * 3.
    dut_log.delete();
    set_op(2, -5, 3);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    cycle();
    idle(3);
    check_val("single_count", dut_log.size(), 1);
    if (dut_log.size() == 1) begin
      check_val("single_p", dut_log[0].p, -15);
      check_val("single_id", dut_log[0].id, 2);
    end
    $display("single req2: p=%0d", dut_log.size() > 0 ? dut_log[0].p : 0);

    // Extremes on requester 0.
    dut_log.delete();
    set_op(0, -2097152, 127); req_valid = 4'b0001; rsp_ready = 1'b1; cycle();
    set_op(0, 2097151, 127); cycle();
    set_op(0, 12345, 0); cycle();
    idle(3);
    check_val("ext_count", dut_log.size(), 3);
    if (dut_log.size() == 3) begin
      check_val("ext_min", dut_log[0].p, -266338304);
      check_val("ext_max", dut_log[1].p, 266338177);
      check_val("ext_zero", dut_log[2].p, 0);
    end
    $display("extremes: %0d results", dut_log.size());

    // Reset while both stages are full.
    set_op(0, 3, 3);
    set_op(1, 4, 4);
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    cycle();
    cycle();
    #2;
    ap_rst_n = 1'b0;
    #1;
    check_val("mrst_rsp_valid", longint'(rsp_valid), 0);
    check_val("mrst_busy", longint'(busy), 0);
    check_val("mrst_req_ready", longint'(req_ready), 0);
    model_reset();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    dut_log.delete();
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    check_val("mrst_first_grant", longint'(req_ready), 1);
    cycle();
    idle(3);
    check_val("mrst_count", dut_log.size(), 1);
    if (dut_log.size() == 1) check_val("mrst_id", dut_log[0].id, 0);
    $display("mid reset: results after release=%0d", dut_log.size());

    // Randomized traffic against the model.
    dut_pops = 0;
    m_pushes = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        set_op(i, longint'($signed(A_W'($urandom))), int'($urandom_range(0, 127)));
      end
      req_valid = NUM_REQ'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    idle(4);
    check_val("rand_conservation", dut_pops, m_pushes);
    check_val("rand_drained", longint'(busy), 0);
    check_val("starvation_ok", longint'(m_max_wait < NUM_REQ), 1);
    $display("random: accepted=%0d returned=%0d max_wait=%0d", m_pushes, dut_pops, m_max_wait);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
